// File: rtl/interboard_msg_sender_if.sv
// Push-side handshake and parallel interboard bus of the Bingo link transmitter.
// The sender uses the master view; the game FSM / receiver side uses the slave view.
interface interboard_msg_sender_if;
    logic       send_req;
    logic [2:0] send_type;
    logic [4:0] send_number;
    logic       send_ready;
    logic       drop_err;
    logic       busy;
    logic       interboard_en;
    logic [2:0] interboard_msg_type;
    logic [4:0] interboard_number;

    modport master (
        input  send_req, send_type, send_number,
        output send_ready, drop_err, busy,
        output interboard_en, interboard_msg_type, interboard_number
    );

    modport slave (
        output send_req, send_type, send_number,
        input  send_ready, drop_err, busy,
        input  interboard_en, interboard_msg_type, interboard_number
    );
endinterface

// File: rtl/interboard_msg_sender.sv
// Queues {type, number} messages in a 4-deep FIFO and frames each one onto the
// interboard bus as setup / one-cycle strobe / hold, sized for the receiver's delayed enable.
module interboard_msg_sender #(
    parameter int SETUP_CYCLES = 2,
    parameter int HOLD_CYCLES  = 6,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic interboard_rst,
    interboard_msg_sender_if.master link
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD  = 4'(HOLD_CYCLES - 1);
    localparam logic [2:0] FULL_COUNT = 3'(FIFO_DEPTH);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] mem_q [FIFO_DEPTH];
    logic [1:0] wrPtr_q, rdPtr_q;
    logic [2:0] count_q, count_d;
    logic [2:0] type_q, type_d;
    logic [4:0] num_q, num_d;
    logic       en_q, en_d;
    logic       drop_q, drop_d;

    logic full;
    logic push;
    logic pop;

    // Fullness is judged on the registered count, so a same-cycle pop never rescues a push.
    assign full = (count_q == FULL_COUNT);
    assign push = link.send_req && !full;
    assign pop  = (state_q == IDLE) && (count_q != 3'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        num_d   = num_q;
        count_d = count_q;
        en_d    = 1'b0;
        drop_d  = 1'b0;

        if (interboard_rst) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            type_d  = 3'd0;
            num_d   = 5'd0;
            count_d = 3'd0;
        end else begin
            drop_d  = link.send_req && full;
            count_d = count_q + 3'(push) - 3'(pop);
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        {type_d, num_d} = mem_q[rdPtr_q];
                        cnt_d           = SETUP_LOAD;
                        state_d         = SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == 4'd0) state_d = STROBE;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                STROBE: begin
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end
                HOLD: begin
                    if (cnt_q == 4'd0) state_d = IDLE;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                default: state_d = IDLE;
            endcase
            en_d = (state_d == STROBE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            count_q <= 3'd0;
            type_q  <= 3'd0;
            num_q   <= 5'd0;
            en_q    <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            type_q  <= type_d;
            num_q   <= num_d;
            en_q    <= en_d;
            drop_q  <= drop_d;
        end
    end

    // Storage and pointers; a link restart empties the queue by rewinding both pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= 2'd0;
            rdPtr_q <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else if (interboard_rst) begin
            wrPtr_q <= 2'd0;
            rdPtr_q <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wrPtr_q] <= {link.send_type, link.send_number};
                wrPtr_q        <= wrPtr_q + 2'd1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 2'd1;
            end
        end
    end

    assign link.send_ready          = !full;
    assign link.drop_err            = drop_q;
    assign link.busy                = (state_q != IDLE) || (count_q != 3'd0);
    assign link.interboard_en       = en_q;
    assign link.interboard_msg_type = type_q;
    assign link.interboard_number   = num_q;

endmodule

// File: tb/tb_interboard_msg_sender.sv
// Self-checking bench: directed scenarios with literal expectations plus a random phase,
// all compared every cycle against a queue-based model of the message framing.
module tb_interboard_msg_sender;

    localparam int SETUP = 2;
    localparam int HOLDC = 6;
    localparam int DEPTH = 4;
    localparam int FRAME_LEN = SETUP + HOLDC + 1;
    localparam logic [2:0] SEL_NUM   = 3'd2;
    localparam logic [2:0] STATE_WIN = 3'd4;

    logic clk;
    logic rstN;
    logic interboardRst;

    interboard_msg_sender_if link ();

    interboard_msg_sender #(
        .SETUP_CYCLES(SETUP),
        .HOLD_CYCLES (HOLDC),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rstN),
        .interboard_rst(interboardRst),
        .link          (link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cycNow = 0;
    bit checkEn = 1'b0;
    bit watchBad = 1'b0;
    int badSeen = 0;
    int enCycle[$];
    int enNum[$];

    // Model state: pending messages, position inside the current frame (0 = link idle).
    logic [7:0] mq[$];
    int         framePos;
    logic [2:0] mType;
    logic [4:0] mNum;
    logic       mDrop;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelClear();
        mq.delete();
        framePos = 0;
        mType = 3'd0;
        mNum = 5'd0;
        mDrop = 1'b0;
    endtask

    task automatic modelStep();
        int sz;
        if (!rstN || interboardRst) begin
            modelClear();
            return;
        end
        sz = mq.size();
        mDrop = link.send_req && (sz == DEPTH);
        if (framePos == 0 && sz != 0) begin
            {mType, mNum} = mq.pop_front();
            framePos = 1;
        end else if (framePos != 0) begin
            framePos = (framePos == FRAME_LEN) ? 0 : framePos + 1;
        end
        if (link.send_req && sz != DEPTH) mq.push_back({link.send_type, link.send_number});
    endtask

    initial begin
        modelClear();
        forever begin
            @(posedge clk or negedge rstN);
            modelStep();
        end
    end

    initial forever begin
        @(posedge clk);
        cycNow++;
    end

    // Compare process: every mid-cycle, outside reset, DUT outputs against the model.
    initial forever begin
        @(negedge clk);
        if (rstN) begin
            if (link.interboard_en) begin
                enCycle.push_back(cycNow);
                enNum.push_back(int'(link.interboard_number));
            end
            if (watchBad && (link.interboard_number == 5'd9 || link.interboard_number == 5'd10))
                badSeen++;
            if (checkEn) begin
                checkOutput("cmp_en", link.interboard_en, framePos == SETUP + 1);
                checkOutput("cmp_type", link.interboard_msg_type, mType);
                checkOutput("cmp_number", link.interboard_number, mNum);
                checkOutput("cmp_ready", link.send_ready, mq.size() != DEPTH);
                checkOutput("cmp_drop", link.drop_err, mDrop);
                checkOutput("cmp_busy", link.busy, framePos != 0 || mq.size() != 0);
            end
        end
    end

    task automatic applyStimulus(input logic req, input logic [2:0] t, input logic [4:0] n,
                                 input logic irst);
        link.send_req = req;
        link.send_type = t;
        link.send_number = n;
        interboardRst = irst;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 5'd0, 1'b0);
    endtask

    task automatic clearLog();
        enCycle.delete();
        enNum.delete();
    endtask

    initial begin
        int start;
        rstN = 1'b0;
        interboardRst = 1'b0;
        link.send_req = 1'b0;
        link.send_type = 3'd0;
        link.send_number = 5'd0;
        #23;
        checkOutput("rst_ready", link.send_ready, 1);
        checkOutput("rst_en", link.interboard_en, 0);
        checkOutput("rst_busy", link.busy, 0);
        checkOutput("rst_number", link.interboard_number, 0);
        @(negedge clk);
        rstN = 1'b1;
        checkEn = 1'b1;
        @(posedge clk);
        #1;
        idleCycles(2);

        $display("[TB] single SEL_NUM 17");
        applyStimulus(1'b1, SEL_NUM, 5'd17, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            checkOutput("t1_en", link.interboard_en, k == 4);
            checkOutput("t1_busy", link.busy, k <= 10);
            if (k >= 2) begin
                checkOutput("t1_type", link.interboard_msg_type, SEL_NUM);
                checkOutput("t1_number", link.interboard_number, 17);
            end
            applyStimulus(1'b0, 3'd0, 5'd0, 1'b0);
        end
        idleCycles(3);

        $display("[TB] five back-to-back requests");
        clearLog();
        start = cycNow;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, SEL_NUM, 5'(i), 1'b0);
            checkOutput("t2_drop", link.drop_err, 0);
        end
        idleCycles(50);
        checkOutput("t2_pulses", enCycle.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < enCycle.size()) begin
                checkOutput("t2_en_cycle", enCycle[i] - start, 4 + 10 * i);
                checkOutput("t2_en_number", enNum[i], i + 1);
            end
        end

        $display("[TB] full FIFO during HOLD and at IDLE pop");
        clearLog();
        watchBad = 1'b1;
        badSeen = 0;
        applyStimulus(1'b1, STATE_WIN, 5'd20, 1'b0);
        idleCycles(4);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, SEL_NUM, 5'(21 + i), 1'b0);
        checkOutput("t3_ready_full", link.send_ready, 0);
        applyStimulus(1'b1, SEL_NUM, 5'd9, 1'b0);
        checkOutput("t3_drop_hold", link.drop_err, 1);
        checkOutput("t3_ready_hold", link.send_ready, 0);
        applyStimulus(1'b0, 3'd0, 5'd0, 1'b0);
        checkOutput("t3_drop_once", link.drop_err, 0);
        checkOutput("t3_ready_idle", link.send_ready, 0);
        applyStimulus(1'b1, SEL_NUM, 5'd10, 1'b0);
        checkOutput("t3_drop_pop", link.drop_err, 1);
        checkOutput("t3_ready_after_pop", link.send_ready, 1);
        idleCycles(50);
        checkOutput("t3_bad_number_seen", badSeen, 0);
        checkOutput("t3_pulses", enCycle.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < enNum.size()) checkOutput("t3_order", enNum[i], 20 + i);
        end
        watchBad = 1'b0;

        $display("[TB] link restart during HOLD");
        applyStimulus(1'b1, SEL_NUM, 5'd7, 1'b0);
        applyStimulus(1'b1, SEL_NUM, 5'd8, 1'b0);
        applyStimulus(1'b1, SEL_NUM, 5'd11, 1'b0);
        idleCycles(4);
        applyStimulus(1'b1, SEL_NUM, 5'd13, 1'b1);
        checkOutput("t4_busy", link.busy, 0);
        checkOutput("t4_number", link.interboard_number, 0);
        checkOutput("t4_type", link.interboard_msg_type, 0);
        checkOutput("t4_drop", link.drop_err, 0);
        checkOutput("t4_ready", link.send_ready, 1);
        clearLog();
        idleCycles(30);
        checkOutput("t4_no_en", enCycle.size(), 0);

        $display("[TB] asynchronous reset mid-SETUP");
        applyStimulus(1'b1, STATE_WIN, 5'd17, 1'b0);
        applyStimulus(1'b0, 3'd0, 5'd0, 1'b0);
        checkOutput("t5_number_before", link.interboard_number, 17);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("t5_en", link.interboard_en, 0);
        checkOutput("t5_type", link.interboard_msg_type, 0);
        checkOutput("t5_number", link.interboard_number, 0);
        checkOutput("t5_ready", link.send_ready, 1);
        checkOutput("t5_busy", link.busy, 0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        clearLog();
        idleCycles(20);
        checkOutput("t5_no_en", enCycle.size(), 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 500; i++) begin
            logic [4:0] n;
            n = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) n = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31;
            applyStimulus($urandom_range(0, 99) < 45, 3'($urandom_range(0, 7)), n,
                          $urandom_range(0, 99) < 2);
        end
        idleCycles(60);
        checkOutput("end_busy", link.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
